// File: rtl/fetch_stage_pkg.sv
// Shared ISA constants for the 16-bit, 4-bit-opcode, 16-register pipeline.
// Fetch, decode and the hazard unit all import this package.
package fetch_stage_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  // Instruction field bit positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;

  localparam logic [3:0] OP_NOR = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_JR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam word_t NOP_WORD = 16'h0000;

  // Fetch FSM states
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // IF/ID register controls
  typedef enum logic [1:0] {
    FD_HOLD   = 2'd0,
    FD_BUBBLE = 2'd1,
    FD_LOAD   = 2'd2
  } fd_ctrl_t;

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds, bubbles or loads the fetched word and its PC+1.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  fd_ctrl_t          ctrl,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc1_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc1_out,
  output logic              valid_out
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;

  // A bubble keeps the stale pc1; only instr/valid matter for a killed slot.
  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    case (ctrl)
      FD_BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      FD_LOAD: begin
        instr_d = instr_in;
        pc1_d   = pc1_in;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc1_out   = pc1_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and RUN/HALT state, feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HLT_OP    = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stl,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] FD_instr,
  output logic [15:0] FD_pc1,
  output logic        FD_valid,
  output logic [3:0]  FD_op,
  output logic [3:0]  FD_rd,
  output logic [3:0]  FD_rs,
  output logic [3:0]  FD_rt,
  output logic        halted
);

  logic [15:0] pc_q, pc_d;
  logic [0:0]  state_q, state_d;
  logic        halted_q, halted_d;
  fd_ctrl_t    fd_ctrl;

  // Priority: redirect > stall > halt > imem wait > normal fetch.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    fd_ctrl = FD_HOLD;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
      fd_ctrl = FD_BUBBLE;
    end else if (stl) begin
      fd_ctrl = FD_HOLD;
    end else if (state_q == ST_HALT) begin
      fd_ctrl = FD_BUBBLE;
    end else if (!imem_rdy) begin
      fd_ctrl = FD_BUBBLE;
    end else begin
      fd_ctrl = FD_LOAD;
      if (imem_data[OP_HI:OP_LO] == HLT_OP) begin
        state_d = ST_HALT;
      end else begin
        pc_d = pc_inc(pc_q);
      end
    end
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (fd_ctrl),
    .instr_in (imem_data),
    .pc1_in   (pc_inc(pc_q)),
    .instr_out(FD_instr),
    .pc1_out  (FD_pc1),
    .valid_out(FD_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign FD_op     = FD_instr[OP_HI:OP_LO];
  assign FD_rd     = FD_instr[RD_HI:RD_LO];
  assign FD_rs     = FD_instr[RS_HI:RS_LO];
  assign FD_rt     = FD_instr[RT_HI:RT_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, wait states, halt, wrap, reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stl, redirect, imem_rdy;
  logic [15:0] redirect_pc, imem_data, imem_addr;
  logic [15:0] FD_instr, FD_pc1;
  logic        FD_valid, halted;
  logic [3:0]  FD_op, FD_rd, FD_rs, FD_rt;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stl        (stl),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_rdy   (imem_rdy),
    .FD_instr   (FD_instr),
    .FD_pc1     (FD_pc1),
    .FD_valid   (FD_valid),
    .FD_op      (FD_op),
    .FD_rd      (FD_rd),
    .FD_rs      (FD_rs),
    .FD_rt      (FD_rt),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stl = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;
    step();
    check("rst_addr",   imem_addr,       16'h0000);
    check("rst_instr",  FD_instr,        16'h0000);
    check("rst_pc1",    FD_pc1,          16'h0000);
    check("rst_valid",  {15'b0, FD_valid}, 16'h0000);
    check("rst_halted", {15'b0, halted},   16'h0000);

    // Sequential fetch
    rst = 1'b0; imem_rdy = 1'b1; imem_data = 16'h1234;
    step();
    check("seq1_instr", FD_instr, 16'h1234);
    check("seq1_pc1",   FD_pc1,   16'h0001);
    check("seq1_op",    {12'b0, FD_op}, 16'h0001);
    check("seq1_rd",    {12'b0, FD_rd}, 16'h0002);
    check("seq1_rs",    {12'b0, FD_rs}, 16'h0003);
    check("seq1_rt",    {12'b0, FD_rt}, 16'h0004);
    check("seq1_valid", {15'b0, FD_valid}, 16'h0001);
    check("seq1_addr",  imem_addr, 16'h0001);
    imem_data = 16'h2345;
    step();
    check("seq2_instr", FD_instr, 16'h2345);
    check("seq2_pc1",   FD_pc1,   16'h0002);
    check("seq2_addr",  imem_addr, 16'h0002);

    // Fill to PC=4, then fetch 8123 so FD=8123 with PC=5
    imem_data = 16'h1000;
    step(); step();
    check("fill_addr", imem_addr, 16'h0004);
    imem_data = 16'h8123;
    step();
    check("pre_stl_instr", FD_instr, 16'h8123);
    check("pre_stl_addr",  imem_addr, 16'h0005);

    // Stall two cycles: everything holds, imem result discarded
    stl = 1'b1; imem_data = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_instr", FD_instr, 16'h8123);
      check("stl_pc1",   FD_pc1,   16'h0005);
      check("stl_valid", {15'b0, FD_valid}, 16'h0001);
      check("stl_addr",  imem_addr, 16'h0005);
    end
    stl = 1'b0; imem_data = 16'h4567;
    step();
    check("resume_instr", FD_instr, 16'h4567);
    check("resume_pc1",   FD_pc1,   16'h0006);
    check("resume_addr",  imem_addr, 16'h0006);

    // Redirect wins over a simultaneous stall
    redirect = 1'b1; redirect_pc = 16'h0040; stl = 1'b1;
    step();
    check("redir_addr",  imem_addr, 16'h0040);
    check("redir_valid", {15'b0, FD_valid}, 16'h0000);
    check("redir_instr", FD_instr, 16'h0000);
    check("redir_rd",    {12'b0, FD_rd}, 16'h0000);
    redirect = 1'b0; stl = 1'b0; imem_data = 16'h5111;
    step();
    check("redir_next_instr", FD_instr, 16'h5111);
    check("redir_next_pc1",   FD_pc1,   16'h0041);
    check("redir_next_addr",  imem_addr, 16'h0042 - 16'h0001);

    // imem wait states at PC=7
    redirect = 1'b1; redirect_pc = 16'h0007;
    step();
    redirect = 1'b0; imem_rdy = 1'b0; imem_data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_valid", {15'b0, FD_valid}, 16'h0000);
      check("wait_addr",  imem_addr, 16'h0007);
    end
    imem_rdy = 1'b1; imem_data = 16'h6222;
    step();
    check("wait_done_instr", FD_instr, 16'h6222);
    check("wait_done_pc1",   FD_pc1,   16'h0008);
    check("wait_done_valid", {15'b0, FD_valid}, 16'h0001);
    check("wait_done_addr",  imem_addr, 16'h0008);

    // Halt at PC=9
    imem_data = 16'h1000;
    step();
    imem_data = 16'hF000;
    step();
    check("hlt_instr",  FD_instr, 16'hF000);
    check("hlt_valid",  {15'b0, FD_valid}, 16'h0001);
    check("hlt_pc1",    FD_pc1,   16'h000A);
    check("hlt_addr",   imem_addr, 16'h0009);
    check("hlt_halted", {15'b0, halted}, 16'h0001);
    imem_data = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_valid",  {15'b0, FD_valid}, 16'h0000);
      check("halt_addr",   imem_addr, 16'h0009);
      check("halt_halted", {15'b0, halted}, 16'h0001);
    end
    redirect = 1'b1; redirect_pc = 16'h0003;
    step();
    check("unhalt_halted", {15'b0, halted}, 16'h0000);
    check("unhalt_addr",   imem_addr, 16'h0003);
    redirect = 1'b0; imem_data = 16'h7333;
    step();
    check("unhalt_instr", FD_instr, 16'h7333);
    check("unhalt_pc1",   FD_pc1,   16'h0004);

    // PC wrap at 16'hFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0; imem_data = 16'h2000;
    step();
    check("wrap_pc1",   FD_pc1,   16'h0000);
    check("wrap_addr",  imem_addr, 16'h0000);
    check("wrap_valid", {15'b0, FD_valid}, 16'h0001);

    // Reset in the middle of HALT
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0; imem_data = 16'hF000;
    step(); step();
    check("pre_rst_halted", {15'b0, halted}, 16'h0001);
    check("pre_rst_addr",   imem_addr, 16'h0020);
    rst = 1'b1;
    step();
    check("mid_rst_halted", {15'b0, halted}, 16'h0000);
    check("mid_rst_addr",   imem_addr, 16'h0000);
    check("mid_rst_valid",  {15'b0, FD_valid}, 16'h0000);
    check("mid_rst_instr",  FD_instr, 16'h0000);
    check("mid_rst_pc1",    FD_pc1,   16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit, 4-bit-opcode, 16-register pipeline.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched word into the FD register and presents the decoded FD_op/FD_rd/FD_rs/FD_rt fields that the hazard detection unit consumes.
- Obeys the hazard unit's stall, EX-stage redirects (branch/jump/JR), instruction-memory wait states and the halt opcode.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word used for bubbles and reset.
- HLT_OP, 4'b1111, opcode that halts fetch.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stl  input  1  stall from hazard unit; freeze PC and FD.
- redirect  input  1  taken branch/jump resolved in EX; flush FD and load PC.
- redirect_pc  input  16  target PC for redirect.
- imem_addr  output  16  instruction-memory word address (= PC, combinational from PC register).
- imem_data  input  16  instruction word at imem_addr, same cycle.
- imem_rdy  input  1  imem_data valid this cycle.
- FD_instr  output  16  latched instruction.
- FD_pc1  output  16  latched PC+1 of FD_instr (link/branch base).
- FD_valid  output  1  FD holds a real instruction (0 = bubble).
- FD_op  output  4  FD_instr[15:12].
- FD_rd  output  4  FD_instr[11:8].
- FD_rs  output  4  FD_instr[7:4].
- FD_rt  output  4  FD_instr[3:0].
- halted  output  1  fetch is halted (HLT latched, no redirect since).

Behaviour:
- Word-addressed PC; next sequential PC = PC+1, 16-bit wrap (16'hFFFF -> 16'h0000, no flag).
- Reset (rst=1 at edge), from any state including mid-halt or mid-wait:
  - PC=RESET_PC, state=RUN.
  - FD_instr=NOP_INSTR, FD_pc1=0, FD_valid=0, halted=0.
- States: RUN, HALT.
- Per-edge priority: rst > redirect > stl > halt > imem wait > normal fetch.
- redirect=1 (any state, regardless of stl or imem_rdy):
  - PC=redirect_pc; FD=bubble (NOP_INSTR, FD_valid=0); state=RUN.
  - The wrong-path FD instruction is killed even if stalled.
- stl=1, no redirect: PC, FD_instr, FD_pc1 and FD_valid all hold; state holds; imem result discarded.
- state=HALT, no redirect, no stl: PC holds; FD=bubble; halted=1.
- RUN, imem_rdy=0: PC holds; FD=bubble.
- RUN, imem_rdy=1:
  - FD_instr=imem_data, FD_pc1=PC+1, FD_valid=1.
  - If imem_data[15:12]==HLT_OP: PC holds and state goes to HALT (HLT itself enters FD with valid=1).
  - Otherwise PC=PC+1.
- halted is a registered output = (state==HALT).
- Latency: one cycle from imem_data valid to FD outputs.
- FD field outputs are pure slices of the FD_instr register. Bubbles decode as NOP_INSTR fields, so the hazard unit sees rd=rs=rt=0 (R0, never forwarded).

Decomposition:
- Shared package: opcode constants (HLT_OP, JR, LW, SW, NOR), NOP_INSTR, 16-bit word width, instruction field bit positions. The hazard unit and decode reuse these.
- One natural sub-module, if_id_reg: the FD register with hold/bubble/load controls. PC/state logic stays in fetch_stage.

Test Plan:
- Reset then imem_rdy=1 with words 16'h1234, 16'h2345: imem_addr 0,1,2; FD_instr 16'h1234 with FD_pc1=1, then 16'h2345 with FD_pc1=2; FD_rs=4'h3, FD_rt=4'h4 for the first.
- stl=1 for 2 cycles while FD=16'h8123 at PC=5: FD_instr, FD_valid and imem_addr=5 hold both cycles; fetch resumes at 5 after stl drops.
- redirect=1 with redirect_pc=16'h0040 and stl=1 in the same cycle: next edge gives imem_addr=16'h0040 and FD_valid=0; the instruction after that comes from 0x40.
- imem_rdy=0 for 3 cycles at PC=7: FD_valid=0 for 3 cycles and PC stays 7; imem_rdy=1 then latches the word with FD_pc1=8.
- Fetch 16'hF000 at PC=9: FD_valid=1 with HLT, then bubbles; halted=1; PC stays 9 indefinitely. redirect to 16'h0003 clears halted and fetches from 3.
- PC=16'hFFFF fetching normally: FD_pc1=16'h0000 and next imem_addr=16'h0000. Asserting rst mid-HALT gives PC=RESET_PC and halted=0 next cycle.
